// File: rtl/mlp_stream_harness.sv
// Streams feature words into a packed vector for a combinational classifier,
// waits a settle period, then captures and offers the class. Option: MLP_HARNESS_CHECK_EN.
//
// state  | meaning
// LOAD   | accepting features into the staging register
// SETTLE | inp held stable, counting down before sampling dut_out
// HOLD   | result presented on out_*, waiting for out_ready
module mlp_stream_harness #(
  parameter int NUM_A         = 6,
  parameter int WIDTH_A       = 4,
  parameter int OUTWIDTH      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_data,
  input  logic [OUTWIDTH-1:0]        exp_label,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        dut_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUTWIDTH-1:0]        out_class,
  output logic                       out_err,
  output logic [15:0]                err_count
);

  localparam int IDXW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int VECW = NUM_A * WIDTH_A;
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_A - 1);
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     feat_idx_q;
  logic [7:0]          cnt_q;
  logic [VECW-1:0]     stage_q, stage_d;
  logic [VECW-1:0]     inp_q;
  logic [OUTWIDTH-1:0] class_q;

  logic in_fire;
  logic last_feat;
  logic settle_done;
  logic out_fire;

  assign in_fire     = in_valid & in_ready;
  assign last_feat   = in_fire && (feat_idx_q == LAST_IDX);
  assign settle_done = (state_q == SETTLE) && (cnt_q == 8'd0);
  assign out_fire    = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (last_feat) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // The final feature goes straight into inp, so the staging update is visible combinationally.
  always_comb begin
    stage_d = stage_q;
    if (in_fire) stage_d[feat_idx_q*WIDTH_A +: WIDTH_A] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      feat_idx_q <= '0;
      cnt_q      <= 8'd0;
      stage_q    <= '0;
      inp_q      <= '0;
      class_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      if (last_feat) begin
        feat_idx_q <= '0;
        inp_q      <= stage_d;
        cnt_q      <= SETTLE_LOAD;
      end else if (in_fire) begin
        feat_idx_q <= feat_idx_q + 1'b1;
      end
      if (state_q == SETTLE && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
      if (settle_done) class_q <= dut_out;
    end
  end

  assign inp       = inp_q;
  assign out_class = class_q;

`ifdef MLP_HARNESS_CHECK_EN
  logic [OUTWIDTH-1:0] label_q;
  logic                err_q;
  logic [15:0]         err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      label_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      if (last_feat) label_q <= exp_label;
      if (settle_done) err_q <= (dut_out != label_q);
      // Saturate rather than wrap so a long soak never reports a small count.
      if (out_fire && err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign out_err   = err_q;
  assign err_count = err_cnt_q;
`else
  logic unused_label;
  logic unused_fire;
  assign unused_label = ^exp_label;
  assign unused_fire  = out_fire;
  assign out_err      = 1'b0;
  assign err_count    = 16'd0;
`endif

endmodule

// File: tb/tb_mlp_stream_harness.sv
// Directed bench for mlp_stream_harness: a default instance and a SETTLE_CYCLES=1
// instance with out_ready tied high; classifier model keyed on the packed vector.
module tb_mlp_stream_harness;

  localparam logic [23:0] V0 = 24'h91F073;  // features 3,7,0,15,1,9 -> class 2
  localparam logic [23:0] V1 = 24'h123456;  // -> class 1
  localparam logic [23:0] V2 = 24'h000001;  // -> class 1

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_data = 4'd0;
  logic [1:0]  exp_label = 2'd0;

  logic        in_ready, out_valid, out_err;
  logic [23:0] inp;
  logic [1:0]  dut_out, out_class;
  logic [15:0] err_count;

  logic        in_ready1, out_valid1, out_err1;
  logic [23:0] inp1;
  logic [1:0]  dut_out1, out_class1;
  logic [15:0] err_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_out  = (inp  == V0) ? 2'd2 : 2'd1;
  assign dut_out1 = (inp1 == V0) ? 2'd2 : 2'd1;

  mlp_stream_harness dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .exp_label(exp_label), .inp(inp), .dut_out(dut_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .err_count(err_count)
  );

  mlp_stream_harness #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .exp_label(exp_label), .inp(inp1), .dut_out(dut_out1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_class(out_class1),
    .out_err(out_err1), .err_count(err_count1)
  );

  task automatic send_vec(input logic sel, input logic [23:0] v, input logic [1:0] lbl);
    for (int i = 0; i < 6; i++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data = v[i*4 +: 4];
      exp_label = lbl;
      while (!(sel ? in_ready1 : in_ready) && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL send_timeout feature %0d never accepted", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input logic sel, output int lat);
    lat = 1;
    while (!(sel ? out_valid1 : out_valid) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic handshake_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (inp !== 24'h0) begin errors++; $display("FAIL rst_inp got %h exp 000000", inp); end
    checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL rst_out_class got %0d exp 0", out_class); end
    checks++; if (out_err !== 1'b0 || err_count !== 16'd0) begin errors++; $display("FAIL rst_err got %b/%0d exp 0/0", out_err, err_count); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    send_vec(1'b0, V0, 2'd2);
    checks++; if (inp !== V0) begin errors++; $display("FAIL basic_inp got %h exp %h", inp, V0); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_settle got rdy=%b vld=%b exp 0/0", in_ready, out_valid); end
    wait_valid(1'b0, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    checks++; if (out_class !== 2'd2) begin errors++; $display("FAIL basic_class got %0d exp 2", out_class); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", out_err); end
    checks++; if (inp !== V0) begin errors++; $display("FAIL basic_inp_hold got %h exp %h", inp, V0); end
    handshake_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_stall();
    int lat;
    send_vec(1'b0, V1, 2'd1);
    wait_valid(1'b0, lat);
    checks++; if (out_class !== 2'd1) begin errors++; $display("FAIL stall_class got %0d exp 1", out_class); end
    in_valid = 1'b1;
    in_data = 4'hA;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got rdy=%b vld=%b cls=%0d exp 0/1/1", c, in_ready, out_valid, out_class);
      end
    end
    in_valid = 1'b0;
    handshake_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    send_vec(1'b0, V0, 2'd2);
    checks++; if (inp !== V0) begin errors++; $display("FAIL stall_no_consume got %h exp %h", inp, V0); end
    wait_valid(1'b0, lat);
    checks++; if (out_class !== 2'd2) begin errors++; $display("FAIL stall_next_class got %0d exp 2", out_class); end
    handshake_out();
  endtask

  task automatic test_mid_reset();
    int lat;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = V1[i*4 +: 4];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pulse_reset();
    checks++; if (inp !== 24'h0 || out_class !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got inp=%h cls=%0d vld=%b exp 0", inp, out_class, out_valid); end
    send_vec(1'b0, V0, 2'd2);
    checks++; if (inp[3:0] !== 4'd3 || inp !== V0) begin errors++; $display("FAIL midrst_align got %h exp %h", inp, V0); end
    wait_valid(1'b0, lat);
    checks++; if (out_class !== 2'd2 || lat != 5) begin errors++; $display("FAIL midrst_result got cls=%0d lat=%0d exp 2/5", out_class, lat); end
    handshake_out();
    send_vec(1'b0, V1, 2'd1);
    @(posedge clk); #1;
    pulse_reset();
    checks++; if (inp !== 24'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL settlerst got inp=%h vld=%b exp 0/0", inp, out_valid); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL settlerst_idle got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_check();
    int lat;
    pulse_reset();
    for (int n = 0; n < 3; n++) begin
      send_vec(1'b0, V2, 2'd2);
      wait_valid(1'b0, lat);
      checks++; if (out_class !== 2'd1) begin errors++; $display("FAIL check_class got %0d exp 1", out_class); end
`ifdef MLP_HARNESS_CHECK_EN
      checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL check_err got %b exp 1", out_err); end
`else
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL check_err got %b exp 0", out_err); end
`endif
      handshake_out();
    end
`ifdef MLP_HARNESS_CHECK_EN
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL check_count got %0d exp 3", err_count); end
`else
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL check_count got %0d exp 0", err_count); end
`endif
    send_vec(1'b0, V0, 2'd2);
    wait_valid(1'b0, lat);
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL check_match_err got %b exp 0", out_err); end
    handshake_out();
  endtask

`ifdef MLP_HARNESS_CHECK_EN
  task automatic test_saturate();
    int lat;
    force dut.err_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    for (int n = 0; n < 3; n++) begin
      send_vec(1'b0, V2, 2'd2);
      wait_valid(1'b0, lat);
      handshake_out();
      checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count vec %0d got %h exp FFFF", n, err_count); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [23:0] vecs [3];
    logic [1:0]  cls  [3];
    int lat;
    vecs[0] = V0; cls[0] = 2'd2;
    vecs[1] = V1; cls[1] = 2'd1;
    vecs[2] = V2; cls[2] = 2'd1;
    pulse_reset();
    for (int n = 0; n < 3; n++) begin
      send_vec(1'b1, vecs[n], 2'd0);
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL b2b_early got vld=%b exp 0", out_valid1); end
      wait_valid(1'b1, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency vec %0d got %0d exp 2", n, lat); end
      checks++; if (out_class1 !== cls[n]) begin errors++; $display("FAIL b2b_class vec %0d got %0d exp %0d", n, out_class1, cls[n]); end
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL b2b_hold_len vec %0d got vld=%b rdy=%b exp 0/1", n, out_valid1, in_ready1); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mid_reset();
    test_check();
`ifdef MLP_HARNESS_CHECK_EN
    test_saturate();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
